// File: rtl/relu_stream_ctrl.sv
// rtl/relu_stream_ctrl.sv - clamped-ReLU tile sequencer with registered valid/ready clamp stage
// Optional clamp-to-ceiling counter: define RELU_SAT_COUNT_EN.
module relu_stream_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int FRACTION_WIDTH = 15,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_cfg_valid,
    input  logic [DATA_WIDTH-1:0]  i_cfg_max_relu,
    input  logic [COUNT_WIDTH-1:0] i_cfg_len,
    output logic                   o_cfg_error,
    input  logic                   i_start,
    output logic                   o_busy,
    output logic                   o_done,
    input  logic                   i_valid,
    input  logic [DATA_WIDTH-1:0]  i_data,
    output logic                   o_ready,
    output logic                   o_valid,
    output logic [DATA_WIDTH-1:0]  o_data,
    input  logic                   i_ready,
    output logic [COUNT_WIDTH-1:0] o_sat_count
);

    localparam int MSB = DATA_WIDTH - 1;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = 1;

    if (FRACTION_WIDTH < 0 || FRACTION_WIDTH > DATA_WIDTH - 1) begin : g_bad_fraction
        $error("FRACTION_WIDTH must fit below the sign bit");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  ceil_q, ceil_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [COUNT_WIDTH-1:0] len_q, len_d;
    logic [COUNT_WIDTH-1:0] rem_q, rem_d;
    logic                   err_q, err_d;
    logic                   valid_q, valid_d;

    logic                   eff_err;
    logic [COUNT_WIDTH-1:0] eff_len;
    logic                   start_ok;
    logic                   accept;
    logic                   clamp_sat;
    logic [DATA_WIDTH-1:0]  clamp_val;

    // A config load in the same cycle as start takes effect for that start.
    assign eff_err  = i_cfg_valid ? i_cfg_max_relu[MSB] : err_q;
    assign eff_len  = i_cfg_valid ? i_cfg_len : len_q;
    assign start_ok = (state_q == S_IDLE) && i_start && !eff_err;

    assign o_ready = (state_q == S_RUN) && (!valid_q || i_ready);
    assign accept  = o_ready && i_valid;

    assign clamp_sat = !i_data[MSB] && (i_data[MSB-1:0] >= ceil_q[MSB-1:0]);
    assign clamp_val = i_data[MSB] ? '0 : (clamp_sat ? ceil_q : i_data);

    always_comb begin
        state_d = state_q;
        ceil_d  = ceil_q;
        len_d   = len_q;
        err_d   = err_q;
        rem_d   = rem_q;
        valid_d = valid_q;
        data_d  = data_q;

        if (accept) begin
            data_d  = clamp_val;
            valid_d = 1'b1;
            rem_d   = rem_q - CNT_ONE;
        end else if (i_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (i_cfg_valid) begin
                    ceil_d = i_cfg_max_relu;
                    len_d  = i_cfg_len;
                    err_d  = i_cfg_max_relu[MSB];
                end
                if (start_ok) begin
                    rem_d   = eff_len;
                    state_d = (eff_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (accept && rem_q == CNT_ONE) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!valid_q || i_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            ceil_q  <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ceil_q  <= ceil_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign o_cfg_error = err_q;
    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = (state_q == S_DONE);
    assign o_valid     = valid_q;
    assign o_data      = data_q;

`ifdef RELU_SAT_COUNT_EN
    logic [COUNT_WIDTH-1:0] sat_q, sat_d;

    always_comb begin
        sat_d = sat_q;
        if (start_ok) begin
            sat_d = '0;
        end else if (accept && clamp_sat && sat_q != '1) begin
            sat_d = sat_q + CNT_ONE;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sat_q <= '0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign o_sat_count = sat_q;
`else
    assign o_sat_count = '0;
`endif

endmodule

// File: tb/tb_relu_stream_ctrl.sv
// tb/tb_relu_stream_ctrl.sv - directed table-driven bench for relu_stream_ctrl
module tb_relu_stream_ctrl;

`ifdef RELU_SAT_COUNT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic        i_clk;
    logic        i_rst;
    logic        i_cfg_valid;
    logic [31:0] i_cfg_max_relu;
    logic [15:0] i_cfg_len;
    logic        o_cfg_error;
    logic        i_start;
    logic        o_busy;
    logic        o_done;
    logic        i_valid;
    logic [31:0] i_data;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_data;
    logic        i_ready;
    logic [15:0] o_sat_count;

    relu_stream_ctrl #(
        .DATA_WIDTH     (32),
        .FRACTION_WIDTH (15),
        .COUNT_WIDTH    (16)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_cfg_valid    (i_cfg_valid),
        .i_cfg_max_relu (i_cfg_max_relu),
        .i_cfg_len      (i_cfg_len),
        .o_cfg_error    (o_cfg_error),
        .i_start        (i_start),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .i_valid        (i_valid),
        .i_data         (i_data),
        .o_ready        (o_ready),
        .o_valid        (o_valid),
        .o_data         (o_data),
        .i_ready        (i_ready),
        .o_sat_count    (o_sat_count)
    );

    typedef struct {
        logic [31:0] din;
        logic [31:0] dout;
    } vec_t;

    vec_t tbl[10];
    int   n_chk  = 0;
    int   n_fail = 0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic configure(input logic [31:0] max, input logic [15:0] len);
        i_cfg_valid    = 1'b1;
        i_cfg_max_relu = max;
        i_cfg_len      = len;
        @(negedge i_clk);
        i_cfg_valid = 1'b0;
    endtask

    task automatic start_tile();
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    // Streams tbl[base +: n]; optional stall on the first output and control pulses mid-tile.
    task automatic stream(input int base, input int n, input int stall_len, input bit ctl_pulse);
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int stalls = 0;
        bit acc_prev = 1'b0;
        bit pulsed = 1'b0;
        while (got < n && cyc < 200) begin
            @(negedge i_clk);
            cyc++;
            if (acc_prev) chk("latency_valid", {31'b0, o_valid}, 32'd1);
            i_cfg_valid = 1'b0;
            i_start     = 1'b0;
            if (o_valid && got == 0 && stalls < stall_len) begin
                i_ready = 1'b0;
                stalls++;
            end else begin
                i_ready = 1'b1;
            end
            i_valid = (sent < n);
            i_data  = (sent < n) ? tbl[base+sent].din : 32'h0;
            if (ctl_pulse && !pulsed && sent == 2) begin
                i_cfg_valid    = 1'b1;
                i_cfg_max_relu = 32'h8000_1000;
                i_cfg_len      = 16'd9;
                i_start        = 1'b1;
                pulsed         = 1'b1;
            end
            #1;
            if (!i_ready) begin
                chk("stall_valid", {31'b0, o_valid}, 32'd1);
                chk("stall_data", o_data, tbl[base].dout);
                chk("stall_ready", {31'b0, o_ready}, 32'd0);
            end
            if (o_valid && i_ready) begin
                chk($sformatf("data[%0d]", base + got), o_data, tbl[base+got].dout);
                got++;
            end
            acc_prev = i_valid && o_ready;
            if (acc_prev) sent++;
        end
        i_valid     = 1'b0;
        i_cfg_valid = 1'b0;
        i_start     = 1'b0;
        chk("tile_outputs", got, n);
        @(negedge i_clk);
        chk("done_pulse", {31'b0, o_done}, 32'd1);
        chk("done_busy", {31'b0, o_busy}, 32'd1);
        chk("done_no_extra_valid", {31'b0, o_valid}, 32'd0);
        @(negedge i_clk);
        chk("done_cleared", {31'b0, o_done}, 32'd0);
        chk("idle_busy", {31'b0, o_busy}, 32'd0);
    endtask

    initial begin
        tbl[0] = '{32'h0001_8000, 32'h0001_8000};
        tbl[1] = '{32'hFFFF_0000, 32'h0000_0000};
        tbl[2] = '{32'h0003_0000, 32'h0003_0000};
        tbl[3] = '{32'h0007_0000, 32'h0003_0000};
        tbl[4] = '{32'h0002_FFFF, 32'h0002_FFFF};
        tbl[5] = '{32'h8000_0000, 32'h0000_0000};
        tbl[6] = '{32'h7FFF_FFFF, 32'h0003_0000};
        tbl[7] = '{32'h0000_0000, 32'h0000_0000};
        tbl[8] = '{32'h0000_8000, 32'h0000_8000};
        tbl[9] = '{32'h0002_0000, 32'h0001_0000};

        i_rst          = 1'b1;
        i_cfg_valid    = 1'b0;
        i_cfg_max_relu = 32'h0;
        i_cfg_len      = 16'h0;
        i_start        = 1'b0;
        i_valid        = 1'b0;
        i_data         = 32'h0;
        i_ready        = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        chk("rst_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_done", {31'b0, o_done}, 32'd0);
        chk("rst_cfg_error", {31'b0, o_cfg_error}, 32'd0);
        chk("rst_busy", {31'b0, o_busy}, 32'd0);
        chk("rst_data", o_data, 32'h0);
        chk("rst_sat", {16'b0, o_sat_count}, 32'd0);
        chk("rst_ready", {31'b0, o_ready}, 32'd0);
        @(negedge i_clk);

        // Full clamp table, ceiling 6.0, no backpressure
        configure(32'h0003_0000, 16'd8);
        start_tile();
        chk("run_busy", {31'b0, o_busy}, 32'd1);
        stream(0, 8, 0, 1'b0);
        chk("sat_table", {16'b0, o_sat_count}, SAT_EN ? 32'd3 : 32'd0);

        // Basic tile with a 3-cycle stall after the first output
        configure(32'h0003_0000, 16'd4);
        start_tile();
        chk("sat_cleared_on_start", {16'b0, o_sat_count}, 32'd0);
        stream(0, 4, 3, 1'b0);
        chk("sat_basic", {16'b0, o_sat_count}, SAT_EN ? 32'd2 : 32'd0);

        // Negative ceiling blocks start; reconfig with start in the same cycle recovers
        configure(32'h8000_1000, 16'd2);
        chk("neg_cfg_error", {31'b0, o_cfg_error}, 32'd1);
        start_tile();
        chk("neg_busy", {31'b0, o_busy}, 32'd0);
        @(negedge i_clk);
        chk("neg_busy_later", {31'b0, o_busy}, 32'd0);
        i_start = 1'b1;
        configure(32'h0001_0000, 16'd2);
        i_start = 1'b0;
        chk("reconfig_error_clear", {31'b0, o_cfg_error}, 32'd0);
        chk("reconfig_busy", {31'b0, o_busy}, 32'd1);
        stream(8, 2, 0, 1'b0);

        // Zero-length tile
        configure(32'h0003_0000, 16'd0);
        i_valid = 1'b1;
        i_data  = 32'h0001_0000;
        start_tile();
        #1;
        chk("zero_busy", {31'b0, o_busy}, 32'd1);
        chk("zero_done", {31'b0, o_done}, 32'd1);
        chk("zero_ready", {31'b0, o_ready}, 32'd0);
        @(negedge i_clk);
        #1;
        chk("zero_busy_after", {31'b0, o_busy}, 32'd0);
        chk("zero_done_after", {31'b0, o_done}, 32'd0);
        chk("zero_ready_after", {31'b0, o_ready}, 32'd0);
        chk("zero_no_output", {31'b0, o_valid}, 32'd0);
        i_valid = 1'b0;
        @(negedge i_clk);

        // Config and start pulsed mid-tile must be ignored
        configure(32'h0003_0000, 16'd4);
        start_tile();
        stream(0, 4, 0, 1'b1);
        chk("ignored_cfg_error", {31'b0, o_cfg_error}, 32'd0);
        start_tile();
        stream(0, 4, 0, 1'b0);

        // Reset after 2 of 5 elements
        configure(32'h0003_0000, 16'd5);
        start_tile();
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = tbl[0].din;
        @(negedge i_clk);
        i_data = tbl[1].din;
        @(negedge i_clk);
        i_valid = 1'b0;
        #1;
        chk("mid_valid_before_rst", {31'b0, o_valid}, 32'd1);
        i_rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'b0, o_valid}, 32'd0);
        chk("mid_rst_busy", {31'b0, o_busy}, 32'd0);
        chk("mid_rst_data", o_data, 32'h0);
        @(negedge i_clk);
        i_rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge i_clk);
            chk("mid_rst_no_done", {31'b0, o_done}, 32'd0);
        end
        chk("mid_rst_idle", {31'b0, o_busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/relu_stream_ctrl.md
Name: relu_stream_ctrl

Overview:
Sequences a clamped-ReLU activation over one feature-map tile of known length. Holds the per-layer ReLU ceiling (configuration) and counts elements through a 1-stage registered clamp with valid/ready on both sides. Signals completion to the layer scheduler. Sits between the accumulator/bias stage and the pooling/writeback stage.

Parameters:
- DATA_WIDTH, 32, total fixed-point width (sign + integer + fraction).
- FRACTION_WIDTH, 15, fraction bits.
- COUNT_WIDTH, 16, width of the tile-length counter.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_cfg_valid  in  1  configuration strobe.
- i_cfg_max_relu  in  DATA_WIDTH  ReLU ceiling.
- i_cfg_len  in  COUNT_WIDTH  number of elements in the tile.
- o_cfg_error  out  1  sticky flag: the latched ceiling is negative.
- i_start  in  1  start-tile pulse.
- o_busy  out  1  state != IDLE.
- o_done  out  1  one-cycle tile-complete pulse.
- i_valid  in  1  input element valid.
- i_data  in  DATA_WIDTH  input element.
- o_ready  out  1  input accept.
- o_valid  out  1  output element valid.
- o_data  out  DATA_WIDTH  clamped element.
- i_ready  in  1  downstream accept.
- o_sat_count  out  COUNT_WIDTH  count of clamped-to-ceiling elements (see Optional Feature).

Behaviour:
- Reset (asynchronous, any state) forces:
  - state = IDLE;
  - o_valid, o_done, o_cfg_error, o_busy = 0;
  - o_data, ceiling register, length register, remaining counter, o_sat_count = 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - i_cfg_valid latches the ceiling and length. o_cfg_error is set to the ceiling's sign bit; it is recomputed on every config load and held otherwise.
  - i_start with o_cfg_error=0 loads remaining = length:
    - length 0 → DONE;
    - otherwise → RUN.
  - i_start with o_cfg_error=1 is ignored.
  - If i_cfg_valid and i_start arrive in the same cycle, the config is applied first; i_start then uses the new values and the new error flag.
- RUN:
  - o_ready = !o_valid || i_ready. o_ready = 0 in every other state.
  - Accept on i_valid && o_ready. On accept: o_data <= clamp(i_data), o_valid <= 1, remaining decrements.
  - Accepting the element with remaining==1 → DRAIN.
- Output register:
  - o_valid clears on i_ready when there is no simultaneous accept.
  - o_data and o_valid are held stable while o_valid && !i_ready.
  - Latency is 1 cycle; back-to-back throughput is 1 element per cycle when i_ready=1.
- DRAIN: when o_valid && i_ready (or o_valid already 0) → DONE.
- DONE: o_done=1 for exactly one cycle, then → IDLE.
- Ignored inputs: i_cfg_valid and i_start are ignored outside IDLE. i_valid is ignored outside RUN.
- clamp(x):
  - x[MSB]=1 → 0.
  - Else, if x[DATA_WIDTH-2:0] ≥ ceiling[DATA_WIDTH-2:0] (unsigned magnitude compare) → ceiling.
  - Else → x.
- Reset asserted mid-tile discards the output register contents; no o_done is produced.

Optional Feature:
- Macro: RELU_SAT_COUNT_EN.
- Defined:
  - o_sat_count increments (saturating at all-ones) on each accepted non-negative element that clamps to the ceiling.
  - Clears on i_start accepted in IDLE.
  - Holds its value after DONE.
- Not defined: o_sat_count is tied to 0; no counter logic is synthesized.

Test Plan:
- Basic tile: config max=0x0003_0000 (6.0), len=4; start; stream 0x0001_8000, 0xFFFF_0000, 0x0003_0000, 0x0007_0000 with i_ready=1.
  - o_data = 0x0001_8000, 0, 0x0003_0000, 0x0003_0000, each 1 cycle after accept.
  - o_done pulses 1 cycle after the last handshake.
  - o_sat_count=2 when RELU_SAT_COUNT_EN is defined.
- Backpressure: same tile with i_ready low for 3 cycles after the first output.
  - o_data/o_valid held stable and o_ready=0 during the stall.
  - No element lost or duplicated; 4 outputs total.
- Negative ceiling: config max=0x8000_1000.
  - o_cfg_error=1; start ignored, o_busy stays 0.
  - Reconfig with max=0x0001_0000 → error clears; start proceeds.
- Zero length: len=0, start → o_busy high for 1 cycle (DONE), o_done pulse, o_ready never asserts.
- Reset mid-tile: assert i_rst after 2 of 5 elements → o_valid=0, o_busy=0, o_done never pulses.
- Ignored controls: i_cfg_valid and i_start pulsed during RUN → ceiling, length and progress unchanged; tile completes with the original configuration.
